// File: rtl/accum_bank_if.sv
// Handshake bundle between the accumulator bank and its write source / drain consumer.
interface accum_bank_if #(
    parameter int COLS  = 2,
    parameter int RW    = 2,
    parameter int IN_W  = 16,
    parameter int ACC_W = 32
);
    logic                    in_valid;
    logic [RW-1:0]           in_row;
    logic                    in_acc;
    logic [COLS*IN_W-1:0]    in_data;
    logic                    swap;
    logic                    swap_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [RW-1:0]           out_row;
    logic                    out_last;
    logic [COLS*ACC_W-1:0]   out_data;
    logic                    busy;
    logic                    ovf;

    modport master (
        output in_valid, in_row, in_acc, in_data, swap, out_ready,
        input  swap_ready, out_valid, out_row, out_last, out_data, busy, ovf
    );

    modport slave (
        input  in_valid, in_row, in_acc, in_data, swap, out_ready,
        output swap_ready, out_valid, out_row, out_last, out_data, busy, ovf
    );
endinterface

// File: rtl/accum_bank.sv
// Double-buffered accumulator bank: one bank accumulates array partial sums while the
// other drains row by row with clear-on-read; a swap exchanges their roles.
module accum_lane #(
    parameter int IN_W     = 16,
    parameter int ACC_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic signed [ACC_W-1:0] cur,
    input  logic signed [IN_W-1:0]  din,
    input  logic                    acc,
    output logic signed [ACC_W-1:0] res,
    output logic                    ovf
);
    logic signed [ACC_W:0] din_x;
    logic signed [ACC_W:0] sum;

    always_comb begin
        din_x = {{(ACC_W+1-IN_W){din[IN_W-1]}}, din};
        sum   = {cur[ACC_W-1], cur} + din_x;
        res   = din_x[ACC_W-1:0];
        ovf   = 1'b0;
        if (acc) begin
            // Sign bits of the widened sum disagree exactly when ACC_W overflows.
            ovf = sum[ACC_W] ^ sum[ACC_W-1];
            res = sum[ACC_W-1:0];
            if (ovf && SATURATE != 0)
                res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
endmodule

module accum_bank #(
    parameter int COLS     = 2,
    parameter int ROWS     = 4,
    parameter int IN_W     = 16,
    parameter int ACC_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic         clk,
    input  logic         reset,
    accum_bank_if.slave  bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW:0]   ROWS_W   = ROWS[RW:0];
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t        state_q;
    logic          cmp_bank_q;
    logic [RW-1:0] drain_row_q;
    logic          ovf_q, ovf_d;

    logic signed [ACC_W-1:0] mem_q [2][ROWS][COLS];
    logic signed [ACC_W-1:0] mem_d [2][ROWS][COLS];

    logic signed [ACC_W-1:0] lane_res [COLS];
    logic [COLS-1:0]         lane_ovf;
    logic [COLS*ACC_W-1:0]   drain_data;

    logic          row_ok, wr_en, swap_acc, rd_fire;
    logic [RW-1:0] wr_idx;

    assign row_ok   = {1'b0, bus.in_row} < ROWS_W;
    assign wr_idx   = row_ok ? bus.in_row : '0;
    assign wr_en    = bus.in_valid && row_ok;
    assign swap_acc = bus.swap && (state_q == IDLE);
    assign rd_fire  = (state_q == DRAIN) && bus.out_ready;

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        accum_lane #(.IN_W(IN_W), .ACC_W(ACC_W), .SATURATE(SATURATE)) u_lane (
            .cur (mem_q[cmp_bank_q][wr_idx][c]),
            .din (bus.in_data[c*IN_W +: IN_W]),
            .acc (bus.in_acc),
            .res (lane_res[c]),
            .ovf (lane_ovf[c])
        );
    end

    // Writes hit only the compute bank and clears only the drain bank, so they never collide.
    always_comb begin
        mem_d = mem_q;
        ovf_d = ovf_q;
        if (swap_acc)
            ovf_d = 1'b0;
        if (wr_en) begin
            for (int c = 0; c < COLS; c++)
                mem_d[cmp_bank_q][wr_idx][c] = lane_res[c];
            if (|lane_ovf)
                ovf_d = 1'b1;
        end
        if (rd_fire)
            for (int c = 0; c < COLS; c++)
                mem_d[~cmp_bank_q][drain_row_q][c] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
            ovf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmp_bank_q  <= 1'b0;
            drain_row_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.swap) begin
                    cmp_bank_q  <= ~cmp_bank_q;
                    drain_row_q <= '0;
                    state_q     <= DRAIN;
                end
                DRAIN: if (bus.out_ready) begin
                    if (drain_row_q == LAST_ROW) begin
                        drain_row_q <= '0;
                        state_q     <= IDLE;
                    end else begin
                        drain_row_q <= drain_row_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        drain_data = '0;
        if (state_q == DRAIN)
            for (int c = 0; c < COLS; c++)
                drain_data[c*ACC_W +: ACC_W] = mem_q[~cmp_bank_q][drain_row_q][c];
    end

    assign bus.swap_ready = (state_q == IDLE);
    assign bus.busy       = (state_q == DRAIN);
    assign bus.out_valid  = (state_q == DRAIN);
    assign bus.out_row    = drain_row_q;
    assign bus.out_last   = (drain_row_q == LAST_ROW);
    assign bus.out_data   = drain_data;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_accum_bank.sv
// Directed bench for accum_bank: default 2x4 bank plus two 1x1 ACC_W=17 banks
// (saturating and wrapping) driven from shared stimulus.
module tb_accum_bank;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    accum_bank_if #(.COLS(2), .RW(2), .IN_W(16), .ACC_W(32)) bus ();
    accum_bank #(.COLS(2), .ROWS(4), .IN_W(16), .ACC_W(32), .SATURATE(1)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    accum_bank_if #(.COLS(1), .RW(1), .IN_W(16), .ACC_W(17)) sat_if ();
    accum_bank_if #(.COLS(1), .RW(1), .IN_W(16), .ACC_W(17)) wrp_if ();
    accum_bank #(.COLS(1), .ROWS(1), .IN_W(16), .ACC_W(17), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .bus(sat_if.slave)
    );
    accum_bank #(.COLS(1), .ROWS(1), .IN_W(16), .ACC_W(17), .SATURATE(0)) dut_wrp (
        .clk(clk), .reset(reset), .bus(wrp_if.slave)
    );

    logic        v_sat, v_wrp, s_row, s_acc, s_swap, s_ready;
    logic [15:0] s_data;
    assign sat_if.in_valid  = v_sat;
    assign wrp_if.in_valid  = v_wrp;
    assign sat_if.in_row    = s_row;
    assign wrp_if.in_row    = s_row;
    assign sat_if.in_acc    = s_acc;
    assign wrp_if.in_acc    = s_acc;
    assign sat_if.in_data   = s_data;
    assign wrp_if.in_data   = s_data;
    assign sat_if.swap      = s_swap;
    assign wrp_if.swap      = s_swap;
    assign sat_if.out_ready = s_ready;
    assign wrp_if.out_ready = s_ready;

    longint e0[4];
    longint e1[4];

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input int c);
        lane = longint'($signed(bus.out_data[c*32 +: 32]));
    endfunction

    task automatic wr(input int row, input bit acc, input int d0, input int d1);
        bus.in_valid = 1'b1;
        bus.in_row   = 2'(row);
        bus.in_acc   = acc;
        bus.in_data  = {16'(d1), 16'(d0)};
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_swap();
        bus.swap = 1'b1;
        @(negedge clk);
        bus.swap = 1'b0;
    endtask

    // Called at the negedge right after an accepted swap; checks all ROWS beats against e0/e1.
    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk({tag, "_vld"},  longint'(bus.out_valid), 1);
            chk({tag, "_row"},  longint'(bus.out_row), r);
            chk({tag, "_last"}, longint'(bus.out_last), longint'(r == 3));
            chk({tag, "_d0"},   lane(0), e0[r]);
            chk({tag, "_d1"},   lane(1), e1[r]);
            @(negedge clk);
        end
        chk({tag, "_rdy_end"}, longint'(bus.swap_ready), 1);
        chk({tag, "_vld_end"}, longint'(bus.out_valid), 0);
    endtask

    initial begin
        bit pat[6];
        int er;
        bus.in_valid = 0; bus.in_row = 0; bus.in_acc = 0; bus.in_data = 0;
        bus.swap = 0; bus.out_ready = 0;
        v_sat = 0; v_wrp = 0; s_row = 0; s_acc = 0; s_data = 0; s_swap = 0; s_ready = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_vld",   longint'(bus.out_valid), 0);
        chk("rst_busy",  longint'(bus.busy), 0);
        chk("rst_srdy",  longint'(bus.swap_ready), 1);
        chk("rst_row",   longint'(bus.out_row), 0);
        chk("rst_last",  longint'(bus.out_last), 0);
        chk("rst_data",  longint'(bus.out_data), 0);
        chk("rst_ovf",   longint'(bus.ovf), 0);
        chk("rst_last1", longint'(sat_if.out_last), 1);

        // basic overwrite + drain
        wr(0, 0, 5, -3);
        wr(1, 0, 100, -1);
        bus.out_ready = 1'b1;
        do_swap();
        e0 = '{5, 100, 0, 0};
        e1 = '{-3, -1, 0, 0};
        drain("t1");

        // accumulate sign extension
        wr(2, 0, -32768, 32767);
        wr(2, 1, -32768, 1);
        chk("t2_ovf", longint'(bus.ovf), 0);
        do_swap();
        e0 = '{0, 0, -65536, 0};
        e1 = '{0, 0, 32768, 0};
        drain("t2");

        // saturate vs wrap at ACC_W=17
        s_ready = 1'b1;
        s_row = 0; s_acc = 0; s_data = 16'd32767; v_sat = 1; v_wrp = 1;
        @(negedge clk);
        chk("t3_ovf_ow_sat", longint'(sat_if.ovf), 0);
        chk("t3_ovf_ow_wrp", longint'(wrp_if.ovf), 0);
        s_acc = 1;
        repeat (2) @(negedge clk);
        v_wrp = 0;
        @(negedge clk);
        v_sat = 0;
        s_row = 1; v_sat = 1; v_wrp = 1;
        @(negedge clk);
        v_sat = 0; v_wrp = 0;
        chk("t3_ovf_sat", longint'(sat_if.ovf), 1);
        chk("t3_ovf_wrp", longint'(wrp_if.ovf), 1);
        s_swap = 1;
        @(negedge clk);
        s_swap = 0;
        chk("t3_vld_sat",  longint'(sat_if.out_valid), 1);
        chk("t3_data_sat", longint'($signed(sat_if.out_data)), 65535);
        chk("t3_data_wrp", longint'($signed(wrp_if.out_data)), -32771);
        chk("t3_clr_sat",  longint'(sat_if.ovf), 0);
        chk("t3_clr_wrp",  longint'(wrp_if.ovf), 0);
        @(negedge clk);
        chk("t3_vld_end",  longint'(sat_if.out_valid), 0);
        chk("t3_srdy_end", longint'(wrp_if.swap_ready), 1);

        // backpressure, swap ignored during drain
        for (int r = 0; r < 4; r++) wr(r, 0, 2*r + 1, 2*r + 2);
        do_swap();
        pat = '{1, 0, 0, 1, 1, 1};
        er = 0;
        for (int i = 0; i < 6; i++) begin
            bus.out_ready = pat[i];
            bus.swap = (i == 1 || i == 2);
            chk("t4_vld",  longint'(bus.out_valid), 1);
            chk("t4_busy", longint'(bus.busy), 1);
            chk("t4_row",  longint'(bus.out_row), er);
            chk("t4_d0",   lane(0), 2*er + 1);
            chk("t4_d1",   lane(1), 2*er + 2);
            @(negedge clk);
            if (pat[i]) er++;
        end
        bus.swap = 1'b0;
        chk("t4_vld_end",  longint'(bus.out_valid), 0);
        chk("t4_srdy_end", longint'(bus.swap_ready), 1);

        // concurrency: write in swap cycle, accumulate during drain
        wr(0, 0, 10, 20);
        bus.in_valid = 1; bus.in_row = 2'd1; bus.in_acc = 0; bus.in_data = {16'd40, 16'd30};
        do_swap();
        bus.in_row = 2'd3; bus.in_acc = 1; bus.in_data = {16'hffff, 16'd1};
        e0 = '{10, 30, 0, 0};
        e1 = '{20, 40, 0, 0};
        drain("t5a");
        bus.in_valid = 0;
        do_swap();
        e0 = '{0, 0, 0, 4};
        e1 = '{0, 0, 0, -4};
        drain("t5b");

        // reset mid-drain
        wr(0, 0, 9, 9);
        wr(1, 0, 9, 9);
        do_swap();
        bus.out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            chk("t6_row", longint'(bus.out_row), r);
            chk("t6_d0",  lane(0), 9);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_vld_rst",  longint'(bus.out_valid), 0);
        chk("t6_srdy_rst", longint'(bus.swap_ready), 1);
        chk("t6_row_rst",  longint'(bus.out_row), 0);
        do_swap();
        e0 = '{0, 0, 0, 0};
        e1 = '{0, 0, 0, 0};
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
